// File: rtl/z80fi_packet_builder_pkg.sv
// Shared types for the z80fi retirement packet builder.
// Pure declarations: no logic, no latency.
// No flow control lives here; see z80fi_packet_builder.
package z80fi_packet_builder_pkg;

    // Instruction tracking state
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    // Per-instruction accumulator: everything gathered while an instruction is open
    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pc;
        logic [3:0]  reg1_num;
        logic [15:0] reg1_data;
        logic [3:0]  reg2_num;
        logic [15:0] reg2_data;
        logic [1:0]  nreg;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [7:0]  mem_data;
        logic        err;
    } acc_t;

    // Retired packet as presented to the checkers
    typedef struct packed {
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pc_rdata;
        logic [15:0] pc_wdata;
        logic [3:0]  reg1_num;
        logic [15:0] reg1_data;
        logic [3:0]  reg2_num;
        logic [15:0] reg2_data;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [7:0]  mem_data;
        logic        err;
    } pkt_t;

    localparam acc_t ACC_CLEAR = '0;

endpackage

// File: rtl/z80fi_packet_builder.sv
// Gathers per-instruction fetches, register reads and memory writes into one z80fi packet.
// Latency: z80fi_valid pulses one cycle after insn_done; data fields hold until the next packet.
// No backpressure: the checkers must accept one packet per cycle; overflowing events are dropped and flagged.
module z80fi_packet_builder
    import z80fi_packet_builder_pkg::*;
#(
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        insn_start,
    input  logic [15:0] insn_pc,
    input  logic        fetch_valid,
    input  logic [7:0]  fetch_data,
    input  logic        reg_rd_valid,
    input  logic [3:0]  reg_rd_num,
    input  logic [15:0] reg_rd_data,
    input  logic        mem_wr_valid,
    input  logic [15:0] mem_wr_addr,
    input  logic [7:0]  mem_wr_data,
    input  logic        insn_done,
    input  logic [15:0] next_pc,
    output logic        z80fi_valid,
    output logic [31:0] z80fi_insn,
    output logic [2:0]  z80fi_insn_len,
    output logic [15:0] z80fi_pc_rdata,
    output logic [15:0] z80fi_pc_wdata,
    output logic [3:0]  z80fi_reg1_rnum,
    output logic [3:0]  z80fi_reg2_rnum,
    output logic [15:0] z80fi_reg1_rdata,
    output logic [15:0] z80fi_reg2_rdata,
    output logic        z80fi_mem_wr,
    output logic [15:0] z80fi_mem_waddr,
    output logic [7:0]  z80fi_mem_wdata,
    output logic        z80fi_err
);

    // Byte slots are addressed with len[1:0], so this must stay 4
    localparam logic [2:0] MAX_LEN = 3'(MAX_INSN_BYTES);

    state_e      state_q, state_d;
    acc_t        acc_q, acc_d;
    acc_t        base, merged;
    pkt_t        pkt_q, pkt_d;
    logic        valid_q, valid_d;
    logic        collecting, retire, restart, take_events;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: done without a new start closes the instruction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (insn_start) state_d = ST_COLLECT;
            ST_COLLECT: if (insn_done && !insn_start) state_d = ST_IDLE;
        endcase
    end

    // State decode: who owns this cycle's events
    always_comb begin
        collecting  = (state_q == ST_COLLECT);
        retire      = collecting && insn_done;
        restart     = collecting && insn_start && !insn_done;
        // On start+done the events belong to the retiring instruction;
        // a lone start hands them to the new one.
        take_events = collecting || (insn_start && !insn_done);
    end

    // Fold this cycle's events into the appropriate accumulator view
    always_comb begin
        base = (collecting && !restart) ? acc_q : ACC_CLEAR;
        // An abandoned partial instruction taints the one that replaces it
        if (restart) base.err = 1'b1;
        merged = base;
        if (take_events) begin
            if (fetch_valid) begin
                if (base.len < MAX_LEN) begin
                    merged.insn[{base.len[1:0], 3'b000} +: 8] = fetch_data;
                    merged.len = base.len + 3'd1;
                end else begin
                    merged.err = 1'b1;
                end
            end
            if (reg_rd_valid) begin
                if (base.nreg == 2'd0) begin
                    merged.reg1_num  = reg_rd_num;
                    merged.reg1_data = reg_rd_data;
                    merged.nreg      = 2'd1;
                end else if (base.nreg == 2'd1) begin
                    merged.reg2_num  = reg_rd_num;
                    merged.reg2_data = reg_rd_data;
                    merged.nreg      = 2'd2;
                end else begin
                    merged.err = 1'b1;
                end
            end
            if (mem_wr_valid) begin
                if (!base.mem_wr) begin
                    merged.mem_wr   = 1'b1;
                    merged.mem_addr = mem_wr_addr;
                    merged.mem_data = mem_wr_data;
                end else begin
                    merged.err = 1'b1;
                end
            end
        end
    end

    // Accumulator update and packet capture on retirement
    always_comb begin
        acc_d   = acc_q;
        pkt_d   = pkt_q;
        valid_d = 1'b0;
        if (retire) begin
            valid_d         = 1'b1;
            pkt_d.insn      = merged.insn;
            pkt_d.len       = merged.len;
            pkt_d.pc_rdata  = merged.pc;
            pkt_d.pc_wdata  = next_pc;
            pkt_d.reg1_num  = merged.reg1_num;
            pkt_d.reg1_data = merged.reg1_data;
            pkt_d.reg2_num  = merged.reg2_num;
            pkt_d.reg2_data = merged.reg2_data;
            pkt_d.mem_wr    = merged.mem_wr;
            pkt_d.mem_addr  = merged.mem_addr;
            pkt_d.mem_data  = merged.mem_data;
            pkt_d.err       = merged.err;
            // Back-to-back: the next instruction opens empty
            acc_d = ACC_CLEAR;
            if (insn_start) acc_d.pc = insn_pc;
        end else if (insn_start) begin
            acc_d    = merged;
            acc_d.pc = insn_pc;
        end else if (collecting) begin
            acc_d = merged;
        end
    end

    // Accumulator and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= ACC_CLEAR;
            pkt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pkt_q   <= pkt_d;
            valid_q <= valid_d;
        end
    end

    assign z80fi_valid      = valid_q;
    assign z80fi_insn       = pkt_q.insn;
    assign z80fi_insn_len   = pkt_q.len;
    assign z80fi_pc_rdata   = pkt_q.pc_rdata;
    assign z80fi_pc_wdata   = pkt_q.pc_wdata;
    assign z80fi_reg1_rnum  = pkt_q.reg1_num;
    assign z80fi_reg1_rdata = pkt_q.reg1_data;
    assign z80fi_reg2_rnum  = pkt_q.reg2_num;
    assign z80fi_reg2_rdata = pkt_q.reg2_data;
    assign z80fi_mem_wr     = pkt_q.mem_wr;
    assign z80fi_mem_waddr  = pkt_q.mem_addr;
    assign z80fi_mem_wdata  = pkt_q.mem_data;
    assign z80fi_err        = pkt_q.err;

endmodule

// File: tb/tb_z80fi_packet_builder.sv
// Bench for z80fi_packet_builder: queue-based instruction model plus literal packet checks.
// Outputs are compared with the model on every falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_z80fi_packet_builder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        insn_start, fetch_valid, reg_rd_valid, mem_wr_valid, insn_done;
    logic [15:0] insn_pc, reg_rd_data, mem_wr_addr, next_pc;
    logic [7:0]  fetch_data, mem_wr_data;
    logic [3:0]  reg_rd_num;
    logic        z80fi_valid, z80fi_mem_wr, z80fi_err;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata, z80fi_reg1_rdata, z80fi_reg2_rdata, z80fi_mem_waddr;
    logic [3:0]  z80fi_reg1_rnum, z80fi_reg2_rnum;
    logic [7:0]  z80fi_mem_wdata;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    z80fi_packet_builder #(.MAX_INSN_BYTES(4)) dut (
        .clk(clk), .reset(reset),
        .insn_start(insn_start), .insn_pc(insn_pc),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .reg_rd_valid(reg_rd_valid), .reg_rd_num(reg_rd_num), .reg_rd_data(reg_rd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .insn_done(insn_done), .next_pc(next_pc),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
        .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg2_rnum(z80fi_reg2_rnum),
        .z80fi_reg1_rdata(z80fi_reg1_rdata), .z80fi_reg2_rdata(z80fi_reg2_rdata),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr),
        .z80fi_mem_wdata(z80fi_mem_wdata), .z80fi_err(z80fi_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An open instruction is a list of everything it saw; the packet is
    // derived from those lists only when it retires.
    bit          m_open = 1'b0;
    bit          m_bad = 1'b0;
    logic [15:0] m_pc = '0;
    logic [7:0]  fq[$];
    logic [3:0]  rnq[$];
    logic [15:0] rdq[$];
    logic [15:0] waq[$];
    logic [7:0]  wdq[$];

    logic        e_valid = 0, e_mem_wr = 0, e_err = 0;
    logic [31:0] e_insn = '0;
    logic [2:0]  e_len = '0;
    logic [15:0] e_pc_r = '0, e_pc_w = '0, e_r1d = '0, e_r2d = '0, e_wa = '0;
    logic [3:0]  e_r1n = '0, e_r2n = '0;
    logic [7:0]  e_wd = '0;

    task automatic m_clear();
        fq.delete(); rnq.delete(); rdq.delete(); waq.delete(); wdq.delete();
    endtask

    task automatic m_take();
        if (fetch_valid)  fq.push_back(fetch_data);
        if (reg_rd_valid) begin rnq.push_back(reg_rd_num); rdq.push_back(reg_rd_data); end
        if (mem_wr_valid) begin waq.push_back(mem_wr_addr); wdq.push_back(mem_wr_data); end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_open = 0; m_bad = 0; m_clear();
            e_valid = 0; e_insn = 0; e_len = 0; e_pc_r = 0; e_pc_w = 0;
            e_r1n = 0; e_r1d = 0; e_r2n = 0; e_r2d = 0;
            e_mem_wr = 0; e_wa = 0; e_wd = 0; e_err = 0;
        end else begin
            e_valid = 0;
            if (m_open && insn_done) begin
                m_take();
                e_len  = (fq.size() > 4) ? 3'd4 : 3'(fq.size());
                e_insn = 0;
                for (int i = 0; i < int'(e_len); i++) e_insn = e_insn | (32'(fq[i]) << (8 * i));
                e_r1n = (rnq.size() > 0) ? rnq[0] : 4'd0;
                e_r1d = (rdq.size() > 0) ? rdq[0] : 16'd0;
                e_r2n = (rnq.size() > 1) ? rnq[1] : 4'd0;
                e_r2d = (rdq.size() > 1) ? rdq[1] : 16'd0;
                e_mem_wr = (waq.size() > 0);
                e_wa  = (waq.size() > 0) ? waq[0] : 16'd0;
                e_wd  = (wdq.size() > 0) ? wdq[0] : 8'd0;
                e_err = m_bad || fq.size() > 4 || rnq.size() > 2 || waq.size() > 1;
                e_pc_r = m_pc;
                e_pc_w = next_pc;
                e_valid = 1;
                m_clear();
                m_bad = 0;
                if (insn_start) m_pc = insn_pc;
                else m_open = 0;
            end else if (insn_start) begin
                m_bad = m_open;
                m_open = 1;
                m_clear();
                m_pc = insn_pc;
                if (!insn_done) m_take();
            end else if (m_open) begin
                m_take();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("valid",   z80fi_valid,      e_valid);
        chk("insn",    z80fi_insn,       e_insn);
        chk("len",     z80fi_insn_len,   e_len);
        chk("pc_r",    z80fi_pc_rdata,   e_pc_r);
        chk("pc_w",    z80fi_pc_wdata,   e_pc_w);
        chk("r1n",     z80fi_reg1_rnum,  e_r1n);
        chk("r1d",     z80fi_reg1_rdata, e_r1d);
        chk("r2n",     z80fi_reg2_rnum,  e_r2n);
        chk("r2d",     z80fi_reg2_rdata, e_r2d);
        chk("mem_wr",  z80fi_mem_wr,     e_mem_wr);
        chk("waddr",   z80fi_mem_waddr,  e_wa);
        chk("wdata",   z80fi_mem_wdata,  e_wd);
        chk("err",     z80fi_err,        e_err);
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        insn_start = 0; insn_pc = '0; fetch_valid = 0; fetch_data = '0;
        reg_rd_valid = 0; reg_rd_num = '0; reg_rd_data = '0;
        mem_wr_valid = 0; mem_wr_addr = '0; mem_wr_data = '0;
        insn_done = 0; next_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic fetch(input logic [7:0] b);
        fetch_valid = 1; fetch_data = b;
    endtask

    task automatic rd(input logic [3:0] n, input logic [15:0] d);
        reg_rd_valid = 1; reg_rd_num = n; reg_rd_data = d;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        mem_wr_valid = 1; mem_wr_addr = a; mem_wr_data = d;
    endtask

    task automatic start(input logic [15:0] pc);
        insn_start = 1; insn_pc = pc;
    endtask

    task automatic done(input logic [15:0] npc);
        insn_done = 1; next_pc = npc;
    endtask

    initial begin
        idle_in();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk("rst_valid", z80fi_valid, 1'b0);
        chk("rst_insn",  z80fi_insn, 32'h0);
        chk("rst_err",   z80fi_err, 1'b0);

        // LD (DE),A  (register 9 = DE, 0 = A)
        start(16'h0100); fetch(8'h12); tick();
        rd(4'd9, 16'h4000); tick();
        rd(4'd0, 16'h005A); tick();
        wr(16'h4000, 8'h5A); tick();
        done(16'h0101); tick();
        chk("ld_valid", z80fi_valid, 1'b1);
        chk("ld_insn",  z80fi_insn, 32'h00000012);
        chk("ld_len",   z80fi_insn_len, 3'd1);
        chk("ld_r1",    {z80fi_reg1_rnum, z80fi_reg1_rdata}, {4'd9, 16'h4000});
        chk("ld_r2",    {z80fi_reg2_rnum, z80fi_reg2_rdata}, {4'd0, 16'h005A});
        chk("ld_mem",   {z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {1'b1, 16'h4000, 8'h5A});
        chk("ld_pc",    {z80fi_pc_rdata, z80fi_pc_wdata}, {16'h0100, 16'h0101});
        chk("ld_err",   z80fi_err, 1'b0);
        tick();
        chk("ld_pulse", z80fi_valid, 1'b0);
        chk("ld_hold",  z80fi_insn, 32'h00000012);

        // LD HL,nn: three bytes, no write
        start(16'h0200); fetch(8'h21); tick();
        fetch(8'h34); tick();
        fetch(8'h12); done(16'h0203); tick();
        chk("ld3_insn", z80fi_insn, 32'h00123421);
        chk("ld3_len",  z80fi_insn_len, 3'd3);
        chk("ld3_mem",  z80fi_mem_wr, 1'b0);
        tick();

        // Back-to-back: fetch in the start+done cycle belongs to the retiring one
        start(16'h0300); fetch(8'h3E); tick();
        fetch(8'h77); done(16'h0302); start(16'h0302); tick();
        chk("b2b_insn1", z80fi_insn, 32'h0000773E);
        chk("b2b_len1",  z80fi_insn_len, 3'd2);
        done(16'h0303); tick();
        chk("b2b_valid2", z80fi_valid, 1'b1);
        chk("b2b_insn2",  z80fi_insn, 32'h0);
        chk("b2b_len2",   z80fi_insn_len, 3'd0);
        chk("b2b_pc2",    z80fi_pc_rdata, 16'h0302);
        tick();

        // One packet per cycle with single-cycle instructions
        start(16'h0800); tick();
        for (int k = 0; k < 3; k++) begin
            fetch(8'(8'hA0 + k)); start(16'(16'h0801 + k)); done(16'(16'h0801 + k)); tick();
            chk("rate_valid", z80fi_valid, 1'b1);
            chk("rate_insn",  z80fi_insn, 32'(8'hA0 + k));
        end
        done(16'h0900); tick();
        chk("rate_last", z80fi_valid, 1'b1);
        tick();

        // Overflow: 5 fetches, 3 reads
        start(16'h0400); fetch(8'hAA); tick();
        fetch(8'hBB); tick();
        fetch(8'hCC); tick();
        fetch(8'hDD); tick();
        fetch(8'hEE); rd(4'd2, 16'h0011); tick();
        rd(4'd3, 16'h0022); tick();
        rd(4'd4, 16'h0033); done(16'h0404); tick();
        chk("ovf_insn", z80fi_insn, 32'hDDCCBBAA);
        chk("ovf_len",  z80fi_insn_len, 3'd4);
        chk("ovf_r1",   {z80fi_reg1_rnum, z80fi_reg1_rdata}, {4'd2, 16'h0011});
        chk("ovf_r2",   {z80fi_reg2_rnum, z80fi_reg2_rdata}, {4'd3, 16'h0022});
        chk("ovf_err",  z80fi_err, 1'b1);
        tick();

        // Second memory write dropped
        start(16'h0450); wr(16'h1111, 8'h01); tick();
        wr(16'h2222, 8'h02); done(16'h0451); tick();
        chk("mw2_addr", {z80fi_mem_waddr, z80fi_mem_wdata}, {16'h1111, 8'h01});
        chk("mw2_err",  z80fi_err, 1'b1);
        tick();

        // Restart without done taints the replacement
        start(16'h0700); fetch(8'h11); tick();
        start(16'h0710); fetch(8'h22); tick();
        done(16'h0711); tick();
        chk("rst_c_insn", z80fi_insn, 32'h00000022);
        chk("rst_c_pc",   z80fi_pc_rdata, 16'h0710);
        chk("rst_c_err",  z80fi_err, 1'b1);
        tick();

        // Reset mid-instruction
        start(16'h0500); fetch(8'h01); tick();
        fetch(8'h02); tick();
        reset = 1; done(16'h0502); tick();
        reset = 0;
        chk("midrst_valid", z80fi_valid, 1'b0);
        chk("midrst_insn",  z80fi_insn, 32'h0);
        tick();
        chk("midrst_valid2", z80fi_valid, 1'b0);
        start(16'h0600); fetch(8'h00); tick();
        done(16'h0601); tick();
        chk("after_valid", z80fi_valid, 1'b1);
        chk("after_err",   z80fi_err, 1'b0);
        chk("after_len",   z80fi_insn_len, 3'd1);
        tick();

        // IDLE noise: nothing should happen
        fetch(8'h55); tick();
        chk("noise_v1", z80fi_valid, 1'b0);
        wr(16'h3333, 8'h33); tick();
        chk("noise_v2", z80fi_valid, 1'b0);
        done(16'h9999); tick();
        chk("noise_v3", z80fi_valid, 1'b0);
        start(16'h0A00); tick();
        done(16'h0A01); tick();
        chk("noise_len",  z80fi_insn_len, 3'd0);
        chk("noise_mem",  z80fi_mem_wr, 1'b0);
        chk("noise_pcw",  z80fi_pc_wdata, 16'h0A01);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
